// File: rtl/ibex_multdiv_arbiter_pkg.sv
// Shared types for the two-port multiply/divide arbiter: operator encoding,
// arbiter FSM state and the port count.
package ibex_multdiv_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    function automatic logic md_is_mult(md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_arbiter_if.sv
// Requester-side bundle of the multdiv arbiter: per-port request, response
// and flush signals. Names are from the arbiter's point of view.
interface ibex_multdiv_arbiter_if;
    import ibex_multdiv_arbiter_pkg::*;

    logic [NUM_PORTS-1:0] req_valid_i;
    logic [NUM_PORTS-1:0] req_ready_o;
    md_op_e               req_op_i     [NUM_PORTS];
    logic [1:0]           req_signed_i [NUM_PORTS];
    logic [31:0]          req_a_i      [NUM_PORTS];
    logic [31:0]          req_b_i      [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_valid_o;
    logic [NUM_PORTS-1:0] rsp_ready_i;
    logic [31:0]          rsp_result_o;
    logic [NUM_PORTS-1:0] flush_i;

    modport slave (
        input  req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i,
        input  rsp_ready_i, flush_i,
        output req_ready_o, rsp_valid_o, rsp_result_o
    );

    modport master (
        output req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i,
        output rsp_ready_i, flush_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o
    );

endinterface

// File: rtl/ibex_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or port 0 always first when
// FIXED_PRIO is set. History only advances when a grant is issued.
module ibex_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       gnt_en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last_q;

    // On contention the port not granted last wins; a lone requester always wins.
    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = FIXED_PRIO ? 1'b0 : ~last_q;
        end else begin
            gnt_idx = req[1];
        end
        gnt = 2'b00;
        if (gnt_en && (req != 2'b00)) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Reset to port 1 so that port 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multiply/divide unit between two requesters; one operation is
// in flight at a time and its result is returned to the owning port only.
module ibex_multdiv_arbiter
    import ibex_multdiv_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ibex_multdiv_arbiter_if.slave  bus,
    output logic                   md_mult_en_o,
    output logic                   md_div_en_o,
    output md_op_e                 md_operator_o,
    output logic [1:0]             md_signed_mode_o,
    output logic [31:0]            md_op_a_o,
    output logic [31:0]            md_op_b_o,
    input  logic [31:0]            md_result_i,
    input  logic                   md_ready_i,
    output logic                   busy_o
);

    arb_state_e  state_q, state_d;
    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        owner_q;
    logic        discard_q;
    logic        owner_flush;
    md_op_e      op_q;
    logic [1:0]  signed_q;
    logic [31:0] a_q, b_q, result_q;

    ibex_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid_i),
        .gnt_en  (state_q == ARB_IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign owner_flush = bus.flush_i[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush seen alongside md_ready_i drops the result just like an earlier one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (gnt != 2'b00) state_d = ARB_BUSY;
            ARB_BUSY: if (md_ready_i) state_d = (discard_q || owner_flush) ? ARB_IDLE : ARB_RESP;
            ARB_RESP: if (owner_flush || bus.rsp_ready_i[owner_q]) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Operands are captured at grant so the unit sees stable inputs throughout BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= 1'b0;
            discard_q <= 1'b0;
            op_q      <= MD_OP_MULL;
            signed_q  <= 2'b00;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            result_q  <= 32'd0;
        end else if (gnt != 2'b00) begin
            owner_q   <= gnt_idx;
            discard_q <= 1'b0;
            op_q      <= bus.req_op_i[gnt_idx];
            signed_q  <= bus.req_signed_i[gnt_idx];
            a_q       <= bus.req_a_i[gnt_idx];
            b_q       <= bus.req_b_i[gnt_idx];
        end else if (state_q == ARB_BUSY) begin
            if (owner_flush) begin
                discard_q <= 1'b1;
            end
            if (md_ready_i) begin
                result_q <= md_result_i;
            end
        end
    end

    // Enables stay up for all of BUSY, even when discarding, since the unit stalls without them.
    always_comb begin
        bus.req_ready_o  = gnt;
        bus.rsp_valid_o  = '0;
        bus.rsp_result_o = 32'd0;
        md_mult_en_o     = 1'b0;
        md_div_en_o      = 1'b0;
        md_operator_o    = MD_OP_MULL;
        md_signed_mode_o = 2'b00;
        md_op_a_o        = 32'd0;
        md_op_b_o        = 32'd0;
        busy_o           = (state_q != ARB_IDLE);
        case (state_q)
            ARB_BUSY: begin
                md_mult_en_o     = md_is_mult(op_q);
                md_div_en_o      = !md_is_mult(op_q);
                md_operator_o    = op_q;
                md_signed_mode_o = signed_q;
                md_op_a_o        = a_q;
                md_op_b_o        = b_q;
            end
            ARB_RESP: begin
                bus.rsp_valid_o[owner_q] = 1'b1;
                bus.rsp_result_o         = result_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for the multdiv arbiter with a small fixed-latency
// multiply/divide unit model behind it.
module tb_ibex_multdiv_arbiter;
    import ibex_multdiv_arbiter_pkg::*;

    localparam int UNIT_LAT = 6;

    logic        clk;
    logic        rst_n;
    logic        md_mult_en_o, md_div_en_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o, md_op_b_o;
    logic [31:0] md_result_i;
    logic        md_ready_i;
    logic        busy_o;
    logic [2:0]  unit_cnt;

    int checks = 0;
    int errors = 0;

    ibex_multdiv_arbiter_if bus ();

    ibex_multdiv_arbiter #(
        .FIXED_PRIO (1'b0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .md_mult_en_o     (md_mult_en_o),
        .md_div_en_o      (md_div_en_o),
        .md_operator_o    (md_operator_o),
        .md_signed_mode_o (md_signed_mode_o),
        .md_op_a_o        (md_op_a_o),
        .md_op_b_o        (md_op_b_o),
        .md_result_i      (md_result_i),
        .md_ready_i       (md_ready_i),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] unitCompute(md_op_e op, logic [31:0] a, logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            MD_OP_MULL: return prod[31:0];
            MD_OP_MULH: return prod[63:32];
            MD_OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default:    return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Unit model: only advances while enabled, answers after UNIT_LAT enabled cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_cnt    <= 3'd0;
            md_ready_i  <= 1'b0;
            md_result_i <= 32'd0;
        end else begin
            md_ready_i <= 1'b0;
            if ((md_mult_en_o || md_div_en_o) && !md_ready_i) begin
                if (unit_cnt == 3'(UNIT_LAT - 1)) begin
                    md_ready_i  <= 1'b1;
                    md_result_i <= unitCompute(md_operator_o, md_op_a_o, md_op_b_o);
                    unit_cnt    <= 3'd0;
                end else begin
                    unit_cnt <= unit_cnt + 3'd1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Raise a request, wait for its ready pulse, then withdraw it in the first BUSY cycle.
    task automatic applyStimulus(input string tag, input int port, input md_op_e op,
                                 input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        bus.req_valid_i[port]  = 1'b1;
        bus.req_op_i[port]     = op;
        bus.req_signed_i[port] = 2'b00;
        bus.req_a_i[port]      = a;
        bus.req_b_i[port]      = b;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready_o[port]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_grant"}, 32'(ok), 32'd1);
        @(negedge clk);
        bus.req_valid_i[port] = 1'b0;
        #1;
    endtask

    task automatic waitRsp(input int port, output bit ok, output bit en_ok);
        ok    = 1'b0;
        en_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid_o[port]) begin
                ok = 1'b1;
                break;
            end
            en_ok &= (md_mult_en_o || md_div_en_o);
        end
    endtask

    task automatic waitResponse(input string tag, input int port, input logic [31:0] expected);
        bit ok, en_ok;
        waitRsp(port, ok, en_ok);
        checkOutput({tag, "_rsp_valid"}, 32'(ok), 32'd1);
        checkOutput({tag, "_en_held"}, 32'(en_ok), 32'd1);
        checkOutput({tag, "_result"}, bus.rsp_result_o, expected);
        checkOutput({tag, "_other_valid"}, 32'(bus.rsp_valid_o[1-port]), 32'd0);
        bus.rsp_ready_i[port] = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i[port] = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok, en_ok, seen, rsp_seen;
        int gidx;

        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        bus.flush_i     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.req_op_i[p]     = MD_OP_MULL;
            bus.req_signed_i[p] = 2'b00;
            bus.req_a_i[p]      = 32'd0;
            bus.req_b_i[p]      = 32'd0;
        end
        rst_n = 1'b1;
        #2;
        resetDut();

        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("rst_rsp_result", bus.rsp_result_o, 32'd0);
        checkOutput("rst_enables", {30'd0, md_mult_en_o, md_div_en_o}, 32'd0);

        // Single MULL from port 0
        @(negedge clk);
        applyStimulus("mull", 0, MD_OP_MULL, 32'd6, 32'd7);
        checkOutput("mull_mult_en", 32'(md_mult_en_o), 32'd1);
        checkOutput("mull_div_en", 32'(md_div_en_o), 32'd0);
        checkOutput("mull_op_a", md_op_a_o, 32'd6);
        checkOutput("mull_op_b", md_op_b_o, 32'd7);
        checkOutput("mull_operator", 32'(md_operator_o), 32'(MD_OP_MULL));
        checkOutput("mull_busy", 32'(busy_o), 32'd1);
        checkOutput("mull_no_ready", 32'(bus.req_ready_o), 32'd0);
        waitResponse("mull", 0, 32'h0000_002A);
        checkOutput("mull_idle", 32'(busy_o), 32'd0);
        checkOutput("mull_enables_idle", {30'd0, md_mult_en_o, md_div_en_o}, 32'd0);

        // Contention after reset: grants alternate 0,1,0,1
        resetDut();
        bus.req_op_i[0] = MD_OP_DIV; bus.req_a_i[0] = 32'd100; bus.req_b_i[0] = 32'd10;
        bus.req_op_i[1] = MD_OP_DIV; bus.req_a_i[1] = 32'd81;  bus.req_b_i[1] = 32'd9;
        bus.req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (bus.req_ready_o != 2'b00) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checkOutput($sformatf("rr_grant_seen_%0d", k), 32'(ok), 32'd1);
            checkOutput($sformatf("rr_grant_%0d", k), 32'(bus.req_ready_o), (k % 2 == 0) ? 32'd1 : 32'd2);
            gidx = bus.req_ready_o[1] ? 1 : 0;
            waitResponse($sformatf("rr_rsp_%0d", k), gidx, (gidx == 0) ? 32'd10 : 32'd9);
        end
        bus.req_valid_i = 2'b00;

        // Divide by zero and MULH pass-through
        @(negedge clk);
        applyStimulus("div0", 0, MD_OP_DIV, 32'd5, 32'd0);
        checkOutput("div0_div_en", 32'(md_div_en_o), 32'd1);
        waitResponse("div0", 0, 32'hFFFF_FFFF);
        applyStimulus("rem0", 0, MD_OP_REM, 32'd5, 32'd0);
        waitResponse("rem0", 0, 32'h0000_0005);
        applyStimulus("mulh", 1, MD_OP_MULH, 32'h0001_0000, 32'h0003_0000);
        waitResponse("mulh", 1, 32'h0000_0003);

        // Owner flush three cycles into a port-1 DIV
        applyStimulus("flushb", 1, MD_OP_DIV, 32'd50, 32'd5);
        repeat (2) @(negedge clk);
        bus.flush_i[1] = 1'b1;
        @(negedge clk);
        bus.flush_i[1] = 1'b0;
        seen = 1'b0; rsp_seen = 1'b0; en_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            rsp_seen |= bus.rsp_valid_o[1];
            if (!seen) en_ok &= md_div_en_o;
            if (md_ready_i) seen = 1'b1;
            @(negedge clk);
        end
        #1;
        checkOutput("flushb_unit_done", 32'(seen), 32'd1);
        checkOutput("flushb_en_held", 32'(en_ok), 32'd1);
        checkOutput("flushb_no_rsp", 32'(rsp_seen), 32'd0);
        checkOutput("flushb_idle", 32'(busy_o), 32'd0);

        // Flush of the non-owner is ignored
        applyStimulus("nonowner", 0, MD_OP_MULL, 32'd9, 32'd9);
        bus.flush_i[1] = 1'b1;
        waitResponse("nonowner", 0, 32'd81);
        bus.flush_i[1] = 1'b0;

        // Flush in the same cycle as md_ready_i
        applyStimulus("flushrdy", 0, MD_OP_MULL, 32'd2, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (md_ready_i) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("flushrdy_ready_seen", 32'(seen), 32'd1);
        bus.flush_i[0] = 1'b1;
        @(negedge clk);
        bus.flush_i[0] = 1'b0;
        #1;
        checkOutput("flushrdy_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("flushrdy_idle", 32'(busy_o), 32'd0);

        // Flush while the response is pending
        applyStimulus("flushresp", 0, MD_OP_MULL, 32'd4, 32'd4);
        waitRsp(0, ok, en_ok);
        checkOutput("flushresp_valid", 32'(ok), 32'd1);
        bus.flush_i[0] = 1'b1;
        @(negedge clk);
        bus.flush_i[0] = 1'b0;
        #1;
        checkOutput("flushresp_dropped", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("flushresp_result_zero", bus.rsp_result_o, 32'd0);
        checkOutput("flushresp_idle", 32'(busy_o), 32'd0);

        // Response back-pressure while port 1 waits
        applyStimulus("hold", 0, MD_OP_MULL, 32'd3, 32'd5);
        waitRsp(0, ok, en_ok);
        checkOutput("hold_valid", 32'(ok), 32'd1);
        bus.req_op_i[1] = MD_OP_MULL; bus.req_a_i[1] = 32'd2; bus.req_b_i[1] = 32'd2;
        bus.req_valid_i[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("hold_result_%0d", i), bus.rsp_result_o, 32'd15);
            checkOutput($sformatf("hold_valid_%0d", i), 32'(bus.rsp_valid_o), 32'd1);
            checkOutput($sformatf("hold_no_grant_%0d", i), 32'(bus.req_ready_o), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready_i[0] = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i[0] = 1'b0;
        #1;
        checkOutput("hold_p1_grant", 32'(bus.req_ready_o), 32'd2);
        @(negedge clk);
        bus.req_valid_i[1] = 1'b0;
        waitResponse("hold_p1", 1, 32'd4);

        // Reset in the middle of a MULH
        applyStimulus("rstmid", 0, MD_OP_MULH, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", 32'(busy_o), 32'd0);
        checkOutput("rstmid_enables", {30'd0, md_mult_en_o, md_div_en_o}, 32'd0);
        checkOutput("rstmid_op_a", md_op_a_o, 32'd0);
        checkOutput("rstmid_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus("postrst", 0, MD_OP_MULL, 32'd6, 32'd7);
        waitResponse("postrst", 0, 32'h0000_002A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_arbiter.md
IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = port 0 always wins.
REQ-002 SHALL have clk  input  1  clock, rising-edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  input  2  per-port request valid (index p = 0,1).
REQ-005 SHALL have req_ready_o  output  2  per-port accept; one-cycle pulse on the grant cycle.
REQ-006 SHALL have req_op_i  input  2x md_op_e  per-port operator.
REQ-007 SHALL have req_signed_i  input  2x2  per-port signed_mode.
REQ-008 SHALL have req_a_i, req_b_i  input  2x32  per-port operands.
REQ-009 SHALL have rsp_valid_o  output  2  per-port result valid.
REQ-010 SHALL have rsp_ready_i  input  2  per-port result accept.
REQ-011 SHALL have rsp_result_o  output  32  result, shared by both ports.
REQ-012 SHALL have flush_i  input  2  per-port discard of that port's outstanding operation.
REQ-013 SHALL have md_mult_en_o, md_div_en_o  output  1 each  enables to the multiply/divide unit.
REQ-014 SHALL have md_operator_o  output  md_op_e; md_signed_mode_o  output  2; md_op_a_o, md_op_b_o  output  32 each.
REQ-015 SHALL have md_result_i  input  32 and md_ready_i  input  1, both from the unit.
REQ-016 SHALL have busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-018 IDLE: when any req_valid_i is high, SHALL grant one port, pulse its req_ready_o, latch op/signed/a/b and the owner index, and go to BUSY the next cycle.
REQ-019 Round-robin SHALL grant the port not granted last whenever both ports request; a single requester SHALL be granted regardless of history.
REQ-020 In BUSY, SHALL drive the md_* outputs only from the latched registers, held stable for the whole operation.
REQ-021 In BUSY, md_mult_en_o SHALL be high for MD_OP_MULL/MULH and md_div_en_o SHALL be high for MD_OP_DIV/REM; both SHALL be low in IDLE and RESP.
REQ-022 Enables SHALL NOT be deasserted in BUSY before md_ready_i, because the unit freezes mid-operation when its enables are low.
REQ-023 When md_ready_i is high in BUSY, SHALL capture md_result_i on that edge and go to RESP, or to IDLE if the operation is discarded.
REQ-024 RESP: rsp_valid_o[owner] SHALL be high and rsp_result_o stable until rsp_ready_i[owner]; then SHALL go to IDLE.
REQ-025 No new grant SHALL occur in BUSY or RESP; req_ready_o SHALL be 0 there.
REQ-026 A grant may occur in the IDLE cycle directly after RESP completes, giving back-to-back operations with one idle cycle.
REQ-027 flush_i[owner] in BUSY SHALL set a discard flag; the unit runs to md_ready_i, the result is dropped and no rsp_valid_o is raised.
REQ-028 flush_i[owner] in RESP SHALL drop rsp_valid_o the next cycle and return to IDLE.
REQ-029 flush_i of a non-owner port SHALL have no effect.
REQ-030 A flush in the same cycle as md_ready_i SHALL discard the result.
REQ-031 A flush in the same cycle as a grant SHALL NOT cancel that new grant.
REQ-032 Division by zero and overflow results SHALL pass through unchanged from md_result_i.
REQ-033 rsp_result_o SHALL be 0 when no rsp_valid_o is high.

Reset
REQ-034 On reset, all outputs SHALL be 0, the FSM SHALL be IDLE, the discard flag cleared, and last-grant set to port 1 so port 0 wins first.
REQ-035 Reset SHALL be applied to this block and the unit together; a reset mid-operation SHALL abandon the operation with no response.

Structure
REQ-036 md_op_e SHALL come from the shared ibex package; the arbiter FSM state enum and the port count constant (2) SHALL live in that package.
REQ-037 The round-robin grant logic SHALL be one sub-module, ibex_rr_arb2.

Verification
REQ-038 Port 0 MULL a=6, b=7 -> md_mult_en_o held until md_ready_i, then rsp_valid_o[0] with result 0x0000002A.
REQ-039 Both ports request DIV simultaneously, repeatedly -> grants in order 0,1,0,1; each response goes to the correct port.
REQ-040 DIV a=5, b=0 -> result 0xFFFFFFFF; REM a=5, b=0 -> result 0x00000005.
REQ-041 flush_i[1] 3 cycles into a port-1 DIV -> md_div_en_o stays high until md_ready_i, no rsp_valid_o[1], IDLE afterwards.
REQ-042 rsp_ready_i[0] low for 5 cycles while port 1 requests -> result held stable, req_ready_o[1] low, port 1 granted after the handshake.
REQ-043 rst_n asserted mid-MULH -> all outputs 0 and state IDLE immediately; the first post-reset request from port 0 completes correctly.
